seq_pattern_fsm: RTL and testbench

Parametrised serial pattern-detector state machine, the next generation of our fixed five-state sequence FSM. It consumes one bit per valid cycle and tracks how many leading pattern bits have been matched. It exposes that match depth as the state output, pulses on every full match and counts matches. The pattern, its length and the overlap mode are configurable, so one block replaces per-pattern hand-written FSMs in the sequential target designs.

---
 rtl/seq_pattern_pkg.sv | 17 +
 rtl/seq_prefix_match.sv | 34 +++
 rtl/seq_pattern_fsm.sv | 85 ++++++++
 tb/tb_seq_pattern_fsm.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_pkg.sv
// Shared constants, op encoding and width helper for the serial pattern detector.
package seq_pattern_pkg;

  localparam int SEQ_MAX_N = 16;
  localparam logic [SEQ_MAX_N-1:0] SEQ_DEFAULT_PATTERN = 16'h000B;

  typedef enum logic [1:0] {
    SEQ_OP_IDLE = 2'd0,
    SEQ_OP_BIT  = 2'd1,
    SEQ_OP_LOAD = 2'd2
  } seq_op_e;

  function automatic int state_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Next match depth: longest suffix of the received bits that equals a pattern prefix,
// bounded by the previous depth + 1 (restart after a full match when overlap is off).
module seq_prefix_match
  import seq_pattern_pkg::*;
#(
  parameter int N   = 4,
  parameter int S_W = state_w(N)
) (
  input  logic [N-1:0]   i_pat,
  input  logic [N-1:0]   i_hist,
  input  logic [S_W-1:0] i_base,
  input  logic           i_overlap,
  output logic [S_W-1:0] o_depth
);

  int   w_lim;
  logic w_found;

  always_comb begin
    w_found = 1'b0;
    o_depth = '0;
    if (i_base == S_W'(N)) w_lim = i_overlap ? N : 1;
    else                   w_lim = int'(i_base) + 1;
    // pat >> (N-k) aligns pat[N-1:N-k] with the k newest history bits
    for (int k = N; k >= 1; k--) begin
      if (!w_found && (k <= w_lim) &&
          (((i_hist ^ (i_pat >> (N - k))) & ({N{1'b1}} >> (N - k))) == '0)) begin
        o_depth = S_W'(k);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_pattern_fsm.sv
// Configurable serial pattern detector: depth FSM, match pulse and saturating match counter.
// state | meaning: 0 = no prefix matched, k (1..N-1) = first k pattern bits matched, N = full match
module seq_pattern_fsm
  import seq_pattern_pkg::*;
#(
  parameter int             N               = 4,
  parameter int             CNT_W           = 8,
  parameter logic [N-1:0]   DEFAULT_PATTERN = SEQ_DEFAULT_PATTERN[N-1:0]
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in,
  input  logic                  load,
  input  logic [N-1:0]          pattern_in,
  input  logic                  overlap,
  output logic [state_w(N)-1:0] state_out,
  output logic                  match,
  output logic [CNT_W-1:0]      match_count,
  output logic                  count_sat
);

  localparam int S_W = state_w(N);

  logic [N-1:0]     r_pat;
  logic [N-1:0]     r_hist;
  logic [S_W-1:0]   r_depth;
  logic             r_match;
  logic [CNT_W-1:0] r_count;

  logic [N-1:0]     w_hist_next;
  logic [S_W-1:0]   w_depth_next;
  logic             w_full;
  seq_op_e          w_op;

  assign w_hist_next = (r_hist << 1) | N'(in);
  assign w_full      = (w_depth_next == S_W'(N));

  always_comb begin
    w_op = SEQ_OP_IDLE;
    if (load)          w_op = SEQ_OP_LOAD;
    else if (in_valid) w_op = SEQ_OP_BIT;
  end

  seq_prefix_match #(.N(N), .S_W(S_W)) u_match (
    .i_pat     (r_pat),
    .i_hist    (w_hist_next),
    .i_base    (r_depth),
    .i_overlap (overlap),
    .o_depth   (w_depth_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat   <= DEFAULT_PATTERN;
      r_hist  <= '0;
      r_depth <= '0;
      r_match <= 1'b0;
      r_count <= '0;
    end else begin
      case (w_op)
        SEQ_OP_LOAD: begin
          r_pat   <= pattern_in;
          r_hist  <= '0;
          r_depth <= '0;
          r_match <= 1'b0;
          r_count <= '0;
        end
        SEQ_OP_BIT: begin
          r_hist  <= w_hist_next;
          r_depth <= w_depth_next;
          r_match <= w_full;
          if (w_full && (r_count != {CNT_W{1'b1}})) r_count <= r_count + 1'b1;
        end
        default: r_match <= 1'b0;
      endcase
    end
  end

  assign state_out   = r_depth;
  assign match       = r_match;
  assign match_count = r_count;
  assign count_sat   = (r_count == {CNT_W{1'b1}});

endmodule

// File: tb/tb_seq_pattern_fsm.sv
// Directed and random stimulus for seq_pattern_fsm, checked against a suffix/prefix queue model.
module tb_seq_pattern_fsm;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1, in_valid = 1'b0, in_bit = 1'b0, load = 1'b0, overlap = 1'b1;
  logic [N-1:0] pattern_in = '0;

  logic [2:0] state_a, state_b;
  logic       match_a, match_b, sat_a, sat_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [N-1:0] m_pat;
  bit           m_q[$];
  int           m_depth, m_cnt_a, m_cnt_b;
  bit           m_match;

  always #5 clk = ~clk;

  seq_pattern_fsm #(.N(N), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit), .load(load),
    .pattern_in(pattern_in), .overlap(overlap), .state_out(state_a), .match(match_a),
    .match_count(cnt_a), .count_sat(sat_a));

  seq_pattern_fsm #(.N(N), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit), .load(load),
    .pattern_in(pattern_in), .overlap(overlap), .state_out(state_b), .match(match_b),
    .match_count(cnt_b), .count_sat(sat_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // longest suffix of the received stream that is a prefix of the pattern
  function automatic int longest();
    int best = 0;
    int sz = m_q.size();
    for (int k = 1; k <= sz; k++) begin
      bit ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (m_q[sz - k + i] != m_pat[N - 1 - i]) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  task automatic model_edge(input logic r, ld, v, b, ov, input logic [N-1:0] pin);
    if (r) begin
      m_pat = 4'b1011; m_q.delete(); m_depth = 0; m_match = 0; m_cnt_a = 0; m_cnt_b = 0;
    end else if (ld) begin
      m_pat = pin; m_q.delete(); m_depth = 0; m_match = 0; m_cnt_a = 0; m_cnt_b = 0;
    end else if (v) begin
      if (m_depth == N && !ov) m_q.delete();
      m_q.push_back(b);
      if (m_q.size() > N) void'(m_q.pop_front());
      m_depth = longest();
      m_match = (m_depth == N);
      if (m_match) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3)   m_cnt_b++;
      end
    end else begin
      m_match = 0;
    end
  endtask

  task automatic step(input logic r, ld, v, b, ov, input logic [N-1:0] pin);
    reset = r; load = ld; in_valid = v; in_bit = b; overlap = ov; pattern_in = pin;
    @(posedge clk);
    model_edge(r, ld, v, b, ov, pin);
    #1;
    check("state_a", 32'(state_a), 32'(m_depth));
    check("match_a", 32'(match_a), 32'(m_match));
    check("count_a", 32'(cnt_a),   32'(m_cnt_a));
    check("sat_a",   32'(sat_a),   32'(m_cnt_a == 255));
    check("state_b", 32'(state_b), 32'(m_depth));
    check("match_b", 32'(match_b), 32'(m_match));
    check("count_b", 32'(cnt_b),   32'(m_cnt_b));
    check("sat_b",   32'(sat_b),   32'(m_cnt_b == 3));
  endtask

  task automatic bit_in(input logic b, ov);
    step(1'b0, 1'b0, 1'b1, b, ov, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  initial begin
    logic [6:0] s7;
    logic [2:0] ov_exp [7];
    logic [2:0] nov_exp[7];
    logic ov_cur;
    s7 = 7'b1011011;
    ov_exp  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4};
    nov_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd1};

    do_reset();
    do_reset();

    // overlapping stream 1011011
    for (int i = 0; i < 7; i++) begin
      bit_in(s7[6 - i], 1'b1);
      check("t1_state", 32'(state_a), 32'(ov_exp[i]));
      check("t1_match", 32'(match_a), 32'(i == 3 || i == 6));
    end
    check("t1_count", 32'(cnt_a), 32'd2);
    do_reset();

    // restart mode, same stream
    for (int i = 0; i < 7; i++) begin
      bit_in(s7[6 - i], 1'b0);
      check("t2_state", 32'(state_a), 32'(nov_exp[i]));
    end
    check("t2_count", 32'(cnt_a), 32'd1);
    do_reset();

    // reset discards a partial match
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    check("t3_depth3", 32'(state_a), 32'd3);
    do_reset();
    bit_in(1'b1, 1'b1);
    check("t3_state", 32'(state_a), 32'd1);
    check("t3_match", 32'(match_a), 32'd0);
    check("t3_count", 32'(cnt_a), 32'd0);

    // load 1111 with a simultaneous valid bit that must be dropped
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
    check("t4_load_state", 32'(state_a), 32'd0);
    for (int i = 0; i < 5; i++) bit_in(1'b1, 1'b1);
    check("t4_count", 32'(cnt_a), 32'd2);
    check("t4_state", 32'(state_a), 32'd4);

    // saturation on the 2-bit counter
    do_reset();
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
    check("t5_cnt1", 32'(cnt_b), 32'd1);
    for (int r = 0; r < 4; r++) begin
      bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
      check("t5_cnt", 32'(cnt_b), (r == 0) ? 32'd2 : 32'd3);
      check("t5_sat", 32'(sat_b), (r == 0) ? 32'd0 : 32'd1);
    end
    check("t5_cnt_a", 32'(cnt_a), 32'd5);

    // idle gaps between bits
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bit_in(s7[6 - i], 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
      check("t6_idle_match", 32'(match_a), 32'd0);
      check("t6_state", 32'(state_a), 32'(ov_exp[i]));
    end
    check("t6_count", 32'(cnt_a), 32'd1);

    // random traffic
    ov_cur = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic r, ld, v, b;
      logic [N-1:0] pin;
      r   = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 79) == 0);
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom);
      pin = N'($urandom);
      if ($urandom_range(0, 24) == 0) ov_cur = ~ov_cur;
      step(r, ld, v, b, ov_cur, pin);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
